bv_match_resolve: RTL and testbench
===================================

# bv_match_resolve

Downstream stage of the bit-vector lookup path. It takes the per-SRAM rule bit-vectors read at the addresses generated by the address mux, ANDs them into one match vector, and priority-encodes the lowest-index matching rule. It emits one registered result per lookup with a valid strobe, and keeps saturating hit/miss statistics. It has no backpressure; it runs at line rate, one lookup per clock.

## Interface
- RESULT_WIDTH, 64, rule bit-vector width per SRAM (rules 0..RESULT_WIDTH-1)
- SRAM_NUM, 4, number of SRAM slices whose outputs are ANDed (≥1)
- SRAM_RD_LAT, 1, SRAM read latency in clocks (≥1)
- RULE_ID_WIDTH, 6, width of the rule index; equals clog2(RESULT_WIDTH)
- CNT_WIDTH, 32, statistics counter width
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- key_valid_i  in  1  high in the same cycle the key nibbles and bus_mode are presented to the address mux
- sram_dout_i  in  RESULT_WIDTH*SRAM_NUM  SRAM read data; slice i is [RESULT_WIDTH*i +: RESULT_WIDTH]
- cnt_clr_i  in  1  synchronous clear of both counters
- match_valid_o  out  1  one-cycle strobe per lookup
- match_hit_o  out  1  AND vector non-zero
- match_id_o  out  RULE_ID_WIDTH  lowest set bit index of AND vector; 0 on miss
- match_bv_o  out  RESULT_WIDTH  full AND vector
- hit_cnt_o  out  CNT_WIDTH  lookups with match_hit_o=1
- miss_cnt_o  out  CNT_WIDTH  lookups with match_hit_o=0

## Operation
- Valid alignment: key_valid_i enters a delay line of 1+SRAM_RD_LAT flops. One flop covers the address-mux register; SRAM_RD_LAT flops cover the read. The tap vld_rd marks the cycle in which sram_dout_i belongs to that key.
- Stage A (AND): when vld_rd=1, register bv_a = bitwise AND of all SRAM_NUM slices. Set vld_a <= vld_rd. bv_a updates only when vld_rd=1, and holds otherwise.
- Stage B (encode/output): when vld_a=1, register match_bv_o=bv_a, match_hit_o=|bv_a, and match_id_o=index of the lowest set bit (0 if none). match_valid_o <= vld_a. When vld_a=0, the data outputs hold their last values and match_valid_o=0.
- Priority: bit 0 is the highest-priority rule.
- SRAM_NUM=1: the AND stage passes the slice through.
- Counters: on match_valid_o=1, increment hit_cnt_o or miss_cnt_o. Counters saturate at all-ones and do not wrap.
- cnt_clr_i=1 zeroes both counters next cycle. If an increment occurs in the same cycle, clear wins and that lookup is not counted.
- Reset (asserted anytime, including mid-flight): all valid flops are 0, so in-flight lookups are dropped. All outputs are 0: match_valid_o, match_hit_o, match_id_o, match_bv_o, hit_cnt_o, miss_cnt_o. The first lookup after deassertion behaves normally.
- sram_dout_i outside vld_rd cycles is ignored (X-tolerant).

## Timing
- key_valid_i at cycle T → sram_dout_i sampled at T+1+SRAM_RD_LAT → match_valid_o high at T+3+SRAM_RD_LAT (T+4 with defaults).
- Throughput: one lookup per clock. Back-to-back keys produce back-to-back strobes with no bubbles.
- Counters reflect a lookup one cycle after its match_valid_o strobe.
- All outputs are registered, with no combinational input→output path.
- The priority encoder fits in one cycle for RESULT_WIDTH≤256. Wider vectors require a split stage, and any such split changes the latency, which must be documented.

## Structure
- Shared package bv_pkg:
  - clog2 function used to derive RULE_ID_WIDTH
  - default RESULT_WIDTH and SRAM_NUM constants, common with the address mux
  - a localparam for the mux register latency (1)
- Sub-module bv_prio_enc (combinational, RESULT_WIDTH in; RULE_ID_WIDTH index and any-bit out). It is reused by the future multi-field combiner.
- Top holds the delay line, AND stage, output register and counters.

## Test plan
- Single hit: all 4 slices = 64'h0000_0000_0000_00F0, key_valid_i at T → at T+4: match_valid_o=1, hit=1, id=4, bv=0xF0; hit_cnt_o=1 at T+5.
- Miss via AND: slices 0x1, 0x2, 0x1, 0x1 → hit=0, id=0, bv=0; miss_cnt_o increments by 1.
- Back-to-back: 8 consecutive keys with ids 0..7 encoded (slice value 1<<k) → 8 consecutive strobes, ids 0..7 in order, hit_cnt_o=8.
- Priority: slice vectors with bits 63, 10 and 5 common → id=5; with only bit 63 common → id=63.
- Saturation and clear:
  - with CNT_WIDTH=4, 20 hits → hit_cnt_o holds at 15;
  - cnt_clr_i coincident with a hit → both counters 0 next cycle.
- Reset mid-flight: rst_n low at T+2 for a key issued at T → no strobe, all outputs 0; a key issued after release → strobe exactly 4 cycles later.

Source files
------------

// File: rtl/bv_pkg.sv
// Shared constants and helpers for the bit-vector lookup path
// (address mux and match resolve).
package bv_pkg;

  localparam int RESULT_WIDTH_DEF = 64;
  localparam int SRAM_NUM_DEF     = 4;
  localparam int MUX_LAT          = 1;

  function automatic int bv_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bv_prio_enc.sv
// Combinational lowest-index priority encoder over a rule bit-vector.
// Bit 0 is the highest priority. The index is 0 when no bit is set.
module bv_prio_enc import bv_pkg::*; #(
  parameter int RESULT_WIDTH  = RESULT_WIDTH_DEF,
  parameter int RULE_ID_WIDTH = bv_clog2(RESULT_WIDTH)
) (
  input  logic [RESULT_WIDTH-1:0]  bv,
  output logic [RULE_ID_WIDTH-1:0] id,
  output logic                     any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    id  = '0;
    any = |bv;
    for (int i = RESULT_WIDTH - 1; i >= 0; i--) begin
      if (bv[i]) id = RULE_ID_WIDTH'(i);
    end
  end

endmodule

// File: rtl/bv_match_resolve.sv
// ANDs per-SRAM rule vectors, priority-encodes the winning rule and keeps
// saturating hit/miss statistics. One lookup per clock, no backpressure.
module bv_match_resolve import bv_pkg::*; #(
  parameter int RESULT_WIDTH  = RESULT_WIDTH_DEF,
  parameter int SRAM_NUM      = SRAM_NUM_DEF,
  parameter int SRAM_RD_LAT   = 1,
  parameter int RULE_ID_WIDTH = bv_clog2(RESULT_WIDTH),
  parameter int CNT_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             key_valid_i,
  input  logic [RESULT_WIDTH*SRAM_NUM-1:0] sram_dout_i,
  input  logic                             cnt_clr_i,
  output logic                             match_valid_o,
  output logic                             match_hit_o,
  output logic [RULE_ID_WIDTH-1:0]         match_id_o,
  output logic [RESULT_WIDTH-1:0]          match_bv_o,
  output logic [CNT_WIDTH-1:0]             hit_cnt_o,
  output logic [CNT_WIDTH-1:0]             miss_cnt_o
);

  localparam int DL_LEN = MUX_LAT + SRAM_RD_LAT;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [DL_LEN-1:0]        vld_line;
  logic                     vld_rd;
  logic [RESULT_WIDTH-1:0]  and_bv;
  logic [RESULT_WIDTH-1:0]  bv_p1;
  logic                     vld_p1;
  logic [RULE_ID_WIDTH-1:0] enc_id;
  logic                     enc_any;

  // ---- valid alignment: mux register plus SRAM read latency ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_line <= '0;
    end else begin
      vld_line <= {vld_line[DL_LEN-2:0], key_valid_i};
    end
  end

  assign vld_rd = vld_line[DL_LEN-1];

  always_comb begin
    and_bv = '1;
    for (int s = 0; s < SRAM_NUM; s++) begin
      and_bv = and_bv & sram_dout_i[RESULT_WIDTH*s +: RESULT_WIDTH];
    end
  end

  // ---- stage A: AND of all slices ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_rd) bv_p1 <= and_bv;
  end

  bv_prio_enc #(
    .RESULT_WIDTH  (RESULT_WIDTH),
    .RULE_ID_WIDTH (RULE_ID_WIDTH)
  ) u_prio_enc (
    .bv  (bv_p1),
    .id  (enc_id),
    .any (enc_any)
  );

  // ---- stage B: encode and register outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_valid_o <= 1'b0;
      match_hit_o   <= 1'b0;
      match_id_o    <= '0;
      match_bv_o    <= '0;
    end else begin
      match_valid_o <= vld_p1;
      if (vld_p1) begin
        match_hit_o <= enc_any;
        match_id_o  <= enc_id;
        match_bv_o  <= bv_p1;
      end
    end
  end

  // ---- statistics: clear takes precedence over the coincident increment ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (match_valid_o) begin
      if (match_hit_o) hit_cnt_o  <= sat_inc(hit_cnt_o);
      else             miss_cnt_o <= sat_inc(miss_cnt_o);
    end
  end

endmodule

// File: tb/tb_bv_match_resolve.sv
// Directed-vector bench for bv_match_resolve with hand-computed expectations.
module tb_bv_match_resolve;

  localparam int RW  = 64;
  localparam int SN  = 4;
  localparam int IDW = 6;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              key_valid_i;
  logic [RW*SN-1:0]  sram_dout_i;
  logic              cnt_clr_i;
  logic              match_valid_o;
  logic              match_hit_o;
  logic [IDW-1:0]    match_id_o;
  logic [RW-1:0]     match_bv_o;
  logic [CW-1:0]     hit_cnt_o;
  logic [CW-1:0]     miss_cnt_o;

  bv_match_resolve #(
    .RESULT_WIDTH  (RW),
    .SRAM_NUM      (SN),
    .SRAM_RD_LAT   (1),
    .RULE_ID_WIDTH (IDW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid_i   (key_valid_i),
    .sram_dout_i   (sram_dout_i),
    .cnt_clr_i     (cnt_clr_i),
    .match_valid_o (match_valid_o),
    .match_hit_o   (match_hit_o),
    .match_id_o    (match_id_o),
    .match_bv_o    (match_bv_o),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [RW-1:0]  vs  [0:23][0:3];
  logic           vh  [0:23];
  logic [IDW-1:0] vid [0:23];
  logic [RW-1:0]  vbv [0:23];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                         input logic [RW-1:0] s2, input logic [RW-1:0] s3,
                         input logic h, input logic [IDW-1:0] id, input logic [RW-1:0] bv);
    vs[i][0] = s0; vs[i][1] = s1; vs[i][2] = s2; vs[i][3] = s3;
    vh[i] = h; vid[i] = id; vbv[i] = bv;
  endtask

  function automatic logic [RW*SN-1:0] noise();
    logic [RW*SN-1:0] r;
    for (int k = 0; k < RW*SN/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issue n back-to-back keys; data follows two cycles later, strobe four.
  task automatic run(input int n, input int clr_at);
    for (int c = 0; c < n + 6; c++) begin
      @(posedge clk); #1;
      if (c >= 4 && c - 4 < n) begin
        chk("strobe", match_valid_o, 1);
        chk("hit", match_hit_o, vh[c-4]);
        chk("id", match_id_o, vid[c-4]);
        chk("bv", match_bv_o, vbv[c-4]);
      end else begin
        chk("idle", match_valid_o, 0);
      end
      key_valid_i = (c < n);
      cnt_clr_i   = (c == clr_at);
      if (c >= 2 && c - 2 < n)
        sram_dout_i = {vs[c-2][3], vs[c-2][2], vs[c-2][1], vs[c-2][0]};
      else
        sram_dout_i = noise();
    end
    key_valid_i = 1'b0;
    cnt_clr_i   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, match_valid_o, 0);
    chk({tag, "_hit"}, match_hit_o, 0);
    chk({tag, "_id"}, match_id_o, 0);
    chk({tag, "_bv"}, match_bv_o, 0);
    chk({tag, "_hitcnt"}, hit_cnt_o, 0);
    chk({tag, "_misscnt"}, miss_cnt_o, 0);
  endtask

  task automatic clear_pulse();
    @(posedge clk); #1; cnt_clr_i = 1'b1;
    @(posedge clk); #1; cnt_clr_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; key_valid_i = 1'b0; cnt_clr_i = 1'b0; sram_dout_i = noise();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single hit: bits 4..7 common, lowest is 4
    set_vec(0, 64'hF0, 64'hF0, 64'hF0, 64'hF0, 1'b1, 6'd4, 64'hF0);
    run(1, -1);
    chk("single_hitcnt", hit_cnt_o, 1);
    chk("single_misscnt", miss_cnt_o, 0);

    // Miss through the AND
    set_vec(0, 64'h1, 64'h2, 64'h1, 64'h1, 1'b0, 6'd0, 64'h0);
    run(1, -1);
    chk("miss_misscnt", miss_cnt_o, 1);
    chk("miss_hitcnt", hit_cnt_o, 1);

    clear_pulse();
    chk("clr_hitcnt", hit_cnt_o, 0);
    chk("clr_misscnt", miss_cnt_o, 0);

    // Back-to-back ids 0..7
    for (int k = 0; k < 8; k++) begin
      logic [RW-1:0] b;
      b = 64'h1 << k;
      set_vec(k, b, b, b, b, 1'b1, IDW'(k), b);
    end
    run(8, -1);
    chk("b2b_hitcnt", hit_cnt_o, 8);
    chk("b2b_misscnt", miss_cnt_o, 0);

    // Priority: bits 63,10,5 common -> 5; only bit 63 common -> 63
    set_vec(0, 64'h8000_0000_0000_0421, 64'h8000_0000_0000_0422,
               64'h8000_0000_0000_0424, 64'h8000_0100_0000_0420,
               1'b1, 6'd5, 64'h8000_0000_0000_0420);
    set_vec(1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002,
               64'hC000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               1'b1, 6'd63, 64'h8000_0000_0000_0000);
    run(2, -1);
    chk("prio_hitcnt", hit_cnt_o, 10);

    // Saturation: 20 more hits from zero holds at 15
    clear_pulse();
    for (int k = 0; k < 20; k++)
      set_vec(k, '1, '1, '1, '1, 1'b1, 6'd0, '1);
    run(20, -1);
    chk("sat_hitcnt", hit_cnt_o, 15);
    chk("sat_misscnt", miss_cnt_o, 0);

    // Clear coincident with a hit strobe
    set_vec(0, 64'h300, 64'h300, 64'h200, 64'h300, 1'b1, 6'd9, 64'h200);
    run(1, 4);
    chk("clrwin_hitcnt", hit_cnt_o, 0);
    chk("clrwin_misscnt", miss_cnt_o, 0);

    // Reset mid-flight: key at T, reset at T+2
    set_vec(0, 64'hF0, 64'hF0, 64'hF0, 64'hF0, 1'b1, 6'd4, 64'hF0);
    run(1, -1);
    chk("pre_rst_hitcnt", hit_cnt_o, 1);
    @(posedge clk); #1; key_valid_i = 1'b1; sram_dout_i = noise();
    @(posedge clk); #1; key_valid_i = 1'b0;
    @(posedge clk); #1; sram_dout_i = {4{64'hF0}}; rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #1; rst_n = 1'b1; sram_dout_i = noise();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("dropped_valid", match_valid_o, 0);
      chk("dropped_hitcnt", hit_cnt_o, 0);
    end
    set_vec(0, 64'h0F00, 64'h0F00, 64'h0F00, 64'h0F00, 1'b1, 6'd8, 64'h0F00);
    run(1, -1);
    chk("post_rst_hitcnt", hit_cnt_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
